// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU between two requesters.
// Latency: legal op responds one edge after the accept edge; an illegal control code responds on the accept edge itself.
// Backpressure: one op in flight; req_ready is low until the owner consumes its response (resp_valid & resp_ready).
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    // requester 0
    input  logic             i_req_valid_0,
    output logic             o_req_ready_0,
    input  logic [WIDTH-1:0] i_req_op1_0,
    input  logic [WIDTH-1:0] i_req_op2_0,
    input  logic [2:0]       i_req_cont_0,
    output logic             o_resp_valid_0,
    input  logic             i_resp_ready_0,
    output logic [WIDTH-1:0] o_resp_result_0,
    output logic             o_resp_z_0,
    output logic             o_resp_err_0,
    // requester 1
    input  logic             i_req_valid_1,
    output logic             o_req_ready_1,
    input  logic [WIDTH-1:0] i_req_op1_1,
    input  logic [WIDTH-1:0] i_req_op2_1,
    input  logic [2:0]       i_req_cont_1,
    output logic             o_resp_valid_1,
    input  logic             i_resp_ready_1,
    output logic [WIDTH-1:0] o_resp_result_1,
    output logic             o_resp_z_1,
    output logic             o_resp_err_1,
    // shared ALU
    output logic [WIDTH-1:0] o_alu_op1,
    output logic [WIDTH-1:0] o_alu_op2,
    output logic [2:0]       o_alu_cont,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic             i_alu_z
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic             r_last_grant;
    logic             r_owner;

    logic [WIDTH-1:0] r_alu_op1;
    logic [WIDTH-1:0] r_alu_op2;
    logic [2:0]       r_alu_cont;

    logic             r_resp_valid_0;
    logic [WIDTH-1:0] r_resp_result_0;
    logic             r_resp_z_0;
    logic             r_resp_err_0;
    logic             r_resp_valid_1;
    logic [WIDTH-1:0] r_resp_result_1;
    logic             r_resp_z_1;
    logic             r_resp_err_1;

    // Arbitration and FSM control signals
    logic             w_accept;
    logic             w_grant;
    logic [WIDTH-1:0] w_sel_op1;
    logic [WIDTH-1:0] w_sel_op2;
    logic [2:0]       w_sel_cont;
    logic             w_sel_legal;
    logic             w_owner_resp_rdy;
    logic             w_resp_load;
    logic             w_resp_sel;
    logic [WIDTH-1:0] w_resp_result;
    logic             w_resp_z;
    logic             w_resp_err;
    logic             w_resp_clr;

    // Operand mux follows the grant; codes 100 and 101 are the only unsupported ones.
    assign w_sel_op1        = w_grant ? i_req_op1_1  : i_req_op1_0;
    assign w_sel_op2        = w_grant ? i_req_op2_1  : i_req_op2_0;
    assign w_sel_cont       = w_grant ? i_req_cont_1 : i_req_cont_0;
    assign w_sel_legal      = (w_sel_cont != 3'b100) && (w_sel_cont != 3'b101);
    assign w_owner_resp_rdy = r_owner ? i_resp_ready_1 : i_resp_ready_0;

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, grant and response-load decode
    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_grant       = 1'b0;
        w_resp_load   = 1'b0;
        w_resp_sel    = r_owner;
        w_resp_result = '0;
        w_resp_z      = 1'b0;
        w_resp_err    = 1'b0;
        w_resp_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid_0 || i_req_valid_1) begin
                    w_accept = 1'b1;
                    // On a tie the requester that did not win last time goes first.
                    if (i_req_valid_0 && i_req_valid_1) begin
                        w_grant = ~r_last_grant;
                    end else begin
                        w_grant = i_req_valid_1;
                    end
                    if (w_sel_legal) begin
                        w_next_state = S_EXEC;
                    end else begin
                        // Illegal codes bypass the ALU with a fixed error response.
                        w_resp_load   = 1'b1;
                        w_resp_sel    = w_grant;
                        w_resp_result = '0;
                        w_resp_z      = 1'b1;
                        w_resp_err    = 1'b1;
                        w_next_state  = S_RESP;
                    end
                end
            end
            S_EXEC: begin
                w_resp_load   = 1'b1;
                w_resp_sel    = r_owner;
                w_resp_result = i_alu_result;
                w_resp_z      = i_alu_z;
                w_resp_err    = 1'b0;
                w_next_state  = S_RESP;
            end
            S_RESP: begin
                // The non-owner's resp_ready is deliberately ignored.
                if (w_owner_resp_rdy) begin
                    w_resp_clr   = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign o_req_ready_0 = w_accept && !w_grant;
    assign o_req_ready_1 = w_accept &&  w_grant;

    // Grant bookkeeping and ALU operand registers; ALU inputs only change on a legal accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_alu_cont   <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
            r_owner      <= w_grant;
            if (w_sel_legal) begin
                r_alu_op1  <= w_sel_op1;
                r_alu_op2  <= w_sel_op2;
                r_alu_cont <= w_sel_cont;
            end
        end
    end

    // Per-requester response registers; only the owner's copy is touched.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_resp_valid_0  <= 1'b0;
            r_resp_result_0 <= '0;
            r_resp_z_0      <= 1'b0;
            r_resp_err_0    <= 1'b0;
            r_resp_valid_1  <= 1'b0;
            r_resp_result_1 <= '0;
            r_resp_z_1      <= 1'b0;
            r_resp_err_1    <= 1'b0;
        end else if (w_resp_load) begin
            if (w_resp_sel) begin
                r_resp_valid_1  <= 1'b1;
                r_resp_result_1 <= w_resp_result;
                r_resp_z_1      <= w_resp_z;
                r_resp_err_1    <= w_resp_err;
            end else begin
                r_resp_valid_0  <= 1'b1;
                r_resp_result_0 <= w_resp_result;
                r_resp_z_0      <= w_resp_z;
                r_resp_err_0    <= w_resp_err;
            end
        end else if (w_resp_clr) begin
            if (r_owner) begin
                r_resp_valid_1 <= 1'b0;
            end else begin
                r_resp_valid_0 <= 1'b0;
            end
        end
    end

    assign o_alu_op1       = r_alu_op1;
    assign o_alu_op2       = r_alu_op2;
    assign o_alu_cont      = r_alu_cont;
    assign o_resp_valid_0  = r_resp_valid_0;
    assign o_resp_result_0 = r_resp_result_0;
    assign o_resp_z_0      = r_resp_z_0;
    assign o_resp_err_0    = r_resp_err_0;
    assign o_resp_valid_1  = r_resp_valid_1;
    assign o_resp_result_1 = r_resp_result_1;
    assign o_resp_z_1      = r_resp_z_1;
    assign o_resp_err_1    = r_resp_err_1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the shared ALU.
// Latency: inputs driven and outputs sampled 2 time units after each rising edge.
// Backpressure: resp_ready driven per test; non-owner ready toggled to show it is ignored.
module tb_alu_arbiter;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             req_valid_0, req_valid_1;
    logic             req_ready_0, req_ready_1;
    logic [WIDTH-1:0] req_op1_0, req_op2_0, req_op1_1, req_op2_1;
    logic [2:0]       req_cont_0, req_cont_1;
    logic             resp_valid_0, resp_valid_1;
    logic             resp_ready_0, resp_ready_1;
    logic [WIDTH-1:0] resp_result_0, resp_result_1;
    logic             resp_z_0, resp_z_1, resp_err_0, resp_err_1;
    logic [WIDTH-1:0] alu_op1, alu_op2, alu_result;
    logic [2:0]       alu_cont;
    logic             alu_z;

    int n_checks = 0;
    int n_errs   = 0;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid_0  (req_valid_0),
        .o_req_ready_0  (req_ready_0),
        .i_req_op1_0    (req_op1_0),
        .i_req_op2_0    (req_op2_0),
        .i_req_cont_0   (req_cont_0),
        .o_resp_valid_0 (resp_valid_0),
        .i_resp_ready_0 (resp_ready_0),
        .o_resp_result_0(resp_result_0),
        .o_resp_z_0     (resp_z_0),
        .o_resp_err_0   (resp_err_0),
        .i_req_valid_1  (req_valid_1),
        .o_req_ready_1  (req_ready_1),
        .i_req_op1_1    (req_op1_1),
        .i_req_op2_1    (req_op2_1),
        .i_req_cont_1   (req_cont_1),
        .o_resp_valid_1 (resp_valid_1),
        .i_resp_ready_1 (resp_ready_1),
        .o_resp_result_1(resp_result_1),
        .o_resp_z_1     (resp_z_1),
        .o_resp_err_1   (resp_err_1),
        .o_alu_op1      (alu_op1),
        .o_alu_op2      (alu_op2),
        .o_alu_cont     (alu_cont),
        .i_alu_result   (alu_result),
        .i_alu_z        (alu_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared combinational ALU outside the arbiter
    always_comb begin
        case (alu_cont)
            3'b010:  alu_result = alu_op1 + alu_op2;
            3'b110:  alu_result = alu_op1 - alu_op2;
            3'b000:  alu_result = alu_op1 & alu_op2;
            3'b001:  alu_result = alu_op1 | alu_op2;
            3'b011:  alu_result = ~(alu_op1 | alu_op2);
            3'b111:  alu_result = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
            default: alu_result = 32'd0;
        endcase
        alu_z = (alu_result == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One full transaction with resp_ready tied high for the expected winner g.
    task automatic serve(input string tag, input int g, input logic [31:0] er,
                         input logic ez, input logic ee, input bit ill, input logic [2:0] ecnt);
        #1;
        check({tag, "_rdy0"}, req_ready_0, (g == 0));
        check({tag, "_rdy1"}, req_ready_1, (g == 1));
        tick();
        check({tag, "_cont"}, alu_cont, ecnt);
        if (!ill) begin
            check({tag, "_exec_vld"}, (g == 1) ? resp_valid_1 : resp_valid_0, 1'b0);
            check({tag, "_exec_rdy"}, req_ready_0 | req_ready_1, 1'b0);
            tick();
        end
        check({tag, "_vld"},   (g == 1) ? resp_valid_1  : resp_valid_0,  1'b1);
        check({tag, "_other"}, (g == 1) ? resp_valid_0  : resp_valid_1,  1'b0);
        check({tag, "_res"},   (g == 1) ? resp_result_1 : resp_result_0, er);
        check({tag, "_z"},     (g == 1) ? resp_z_1      : resp_z_0,      ez);
        check({tag, "_err"},   (g == 1) ? resp_err_1    : resp_err_0,    ee);
        tick();
        check({tag, "_done"},  (g == 1) ? resp_valid_1  : resp_valid_0,  1'b0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid_0 = 0; req_op1_0 = 0; req_op2_0 = 0; req_cont_0 = 0;
        req_valid_1 = 0; req_op1_1 = 0; req_op2_1 = 0; req_cont_1 = 0;
        resp_ready_0 = 1; resp_ready_1 = 1;
        do_reset();

        // Reset state
        #1;
        check("rst_vld0", resp_valid_0, 1'b0);
        check("rst_vld1", resp_valid_1, 1'b0);
        check("rst_res0", resp_result_0, 32'd0);
        check("rst_z1",   resp_z_1, 1'b0);
        check("rst_op1",  alu_op1, 32'd0);
        check("rst_cont", alu_cont, 3'b000);
        check("rst_rdy",  req_ready_0 | req_ready_1, 1'b0);

        // Simple add from requester 0
        req_valid_0 = 1; req_op1_0 = 5; req_op2_0 = 7; req_cont_0 = 3'b010;
        serve("add", 0, 32'd12, 1'b0, 1'b0, 1'b0, 3'b010);
        req_valid_0 = 0;

        // Tie after reset: requester 0 first, then alternation while both stay valid
        do_reset();
        req_valid_0 = 1; req_op1_0 = 5; req_op2_0 = 5; req_cont_0 = 3'b110;
        req_valid_1 = 1; req_op1_1 = 3; req_op2_1 = 5; req_cont_1 = 3'b111;
        serve("tie_sub", 0, 32'd0, 1'b1, 1'b0, 1'b0, 3'b110);
        serve("tie_slt", 1, 32'd1, 1'b0, 1'b0, 1'b0, 3'b111);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) serve("alt_r0", 0, 32'd0, 1'b1, 1'b0, 1'b0, 3'b110);
            else            serve("alt_r1", 1, 32'd1, 1'b0, 1'b0, 1'b0, 3'b111);
        end

        // Backpressure on requester 1 (nor 0,0); requester 0 waits with an illegal op
        req_valid_0 = 0;
        req_op1_1 = 0; req_op2_1 = 0; req_cont_1 = 3'b011;
        resp_ready_1 = 0; resp_ready_0 = 1;
        #1;
        check("bp_rdy1", req_ready_1, 1'b1);
        check("bp_rdy0", req_ready_0, 1'b0);
        tick();
        req_valid_1 = 0;
        tick();
        req_valid_0 = 1; req_op1_0 = 32'h1234; req_op2_0 = 32'h5; req_cont_0 = 3'b101;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_vld",  resp_valid_1, 1'b1);
            check("bp_res",  resp_result_1, 32'hFFFF_FFFF);
            check("bp_z",    resp_z_1, 1'b0);
            check("bp_nrdy", req_ready_0 | req_ready_1, 1'b0);
            tick();
        end
        resp_ready_1 = 1;
        #1;
        check("bp_last", resp_valid_1, 1'b1);
        tick();
        check("bp_done", resp_valid_1, 1'b0);

        // Illegal code 101: immediate error response, ALU registers untouched
        serve("ill101", 0, 32'd0, 1'b1, 1'b1, 1'b1, 3'b011);
        check("ill_op1", alu_op1, 32'd0);
        req_valid_0 = 0;

        // Reset while requester 1's op is in EXEC
        req_valid_1 = 1; req_op1_1 = 32'hFF; req_op2_1 = 32'h10; req_cont_1 = 3'b000;
        #1;
        check("mid_rdy1", req_ready_1, 1'b1);
        tick();
        check("mid_op1", alu_op1, 32'hFF);
        req_valid_1 = 0;
        rst = 1;
        tick();
        rst = 0;
        check("mid_vld1", resp_valid_1, 1'b0);
        check("mid_vld0", resp_valid_0, 1'b0);
        check("mid_aop1", alu_op1, 32'd0);
        tick();
        tick();
        check("mid_none", resp_valid_1, 1'b0);

        // Tie priority back to requester 0; signed slt boundary
        req_valid_0 = 1; req_op1_0 = 32'h8000_0000; req_op2_0 = 32'h1; req_cont_0 = 3'b111;
        req_valid_1 = 1; req_op1_1 = 32'hF0; req_op2_1 = 32'h3C; req_cont_1 = 3'b000;
        serve("slt_min", 0, 32'd1, 1'b0, 1'b0, 1'b0, 3'b111);
        req_valid_0 = 0;
        serve("and_r1", 1, 32'h30, 1'b0, 1'b0, 1'b0, 3'b000);

        // Illegal code 100 from requester 1; requester 0 keeps its last response
        req_cont_1 = 3'b100; req_op1_1 = 32'h77;
        serve("ill100", 1, 32'd0, 1'b1, 1'b1, 1'b1, 3'b000);
        req_valid_1 = 0;
        check("keep_res0", resp_result_0, 32'd1);
        check("keep_vld0", resp_valid_0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 32-bit ALU (ops add/sub/and/or/nor/slt selected by a 3-bit control) between two requesters, e.g. the main pipeline execute stage and an auxiliary sequencer. Requests use valid/ready handshakes and are granted round-robin. Operands are registered into the ALU, and the result and zero flag are captured into a per-requester response register. Unsupported control codes are rejected with an error response and never reach the ALU.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid_0 / req_valid_1  in  1  requester has an operation
- req_ready_0 / req_ready_1  out  1  arbiter accepts this cycle (combinational)
- req_op1_0 / req_op1_1  in  WIDTH  operand 1
- req_op2_0 / req_op2_1  in  WIDTH  operand 2
- req_cont_0 / req_cont_1  in  3  ALU control: 010 add, 110 sub, 000 and, 001 or, 011 nor, 111 slt
- resp_valid_0 / resp_valid_1  out  1  response pending for that requester
- resp_ready_0 / resp_ready_1  in  1  requester consumes response
- resp_result_0 / resp_result_1  out  WIDTH  captured ALU result
- resp_z_0 / resp_z_1  out  1  captured zero flag
- resp_err_0 / resp_err_1  out  1  control code was 100 or 101
- alu_op1, alu_op2  out  WIDTH  registered operands to ALU
- alu_cont  out  3  registered control to ALU
- alu_result  in  WIDTH  ALU result
- alu_z  in  1  ALU zero flag

## Operation
- States: IDLE, EXEC, RESP. One operation in flight at a time.
- IDLE: grant = requester with valid. If both are valid, grant goes to the requester that is not last_grant. req_ready_g = 1 for the granted requester only. req_ready is 0 in EXEC and RESP.
- Accept (valid & ready): latch op1/op2/cont into alu_op1/alu_op2/alu_cont, owner <= g, last_grant <= g.
  - Control code legal: go to EXEC.
  - Control code 100/101: alu_* registers are not updated. Load the response with result 0, z 1, err 1. Go to RESP.
- EXEC (1 cycle): capture alu_result/alu_z into owner's resp_result/resp_z, err 0, resp_valid_owner <= 1. Go to RESP.
- RESP: hold resp_* stable until resp_ready_owner = 1. On that edge, resp_valid_owner <= 0 and go to IDLE. No new request is accepted in the same cycle.
- Only the owner's resp_valid is ever 1. The other requester's resp_* registers keep their last values with valid 0.
- alu_op1/alu_op2/alu_cont hold their last accepted values outside EXEC. Bit widths pass through unchanged.
- Reset: state IDLE, last_grant = 1 (requester 0 wins first tie), owner = 0. All outputs 0: resp_valid_*, resp_result_*, resp_z_*, resp_err_*, alu_op1, alu_op2, alu_cont. req_ready_* then follows IDLE rules.

## Timing
- Accept on edge N: alu_* valid after N. Legal op: resp_valid after edge N+1. Illegal op: resp_valid after edge N (no EXEC).
- Minimum spacing between accepts: 3 cycles for a legal op with resp_ready tied high. Minimum spacing is 2 cycles for an illegal op.
- Request held without grant: requester keeps valid and operands stable. The arbiter has no queue.
- Simultaneous valid in IDLE: exactly one ready high, chosen by round-robin. The loser is granted on the next IDLE cycle if still valid, even if the winner re-requests.
- Single requester valid: granted regardless of last_grant.
- rst during EXEC/RESP: in-flight op is dropped. All resp_valid are 0 after the reset edge. The dropped op produces no response. Tie priority returns to requester 0.
- resp_ready of the non-owner is ignored.

## Test plan
- Reset, then req0 add op1=5 op2=7 cont=010 → req_ready_0=1; resp_valid_0 two edges after accept; result 12, z 0, err 0.
- req0 and req1 both valid in the same cycle after reset (req0 sub 5-5, req1 slt 3,5): req0 served first → result 0, z 1. Then req1 → result 1, z 0. With both valid continuously, grants alternate 0,1,0,1.
- Backpressure: req1 nor op1=0 op2=0 with resp_ready_1=0 for 4 cycles → result 0xFFFFFFFF, z 0 held stable, req_ready_* 0 throughout. Completes on the first cycle resp_ready_1=1.
- Illegal code: req0 cont=101 → resp_valid_0 one edge after accept, result 0, z 1, err 1. alu_cont keeps its previous value.
- Reset mid-EXEC after accepting req1 and 0x10 → resp_valid_1 stays 0 and no response appears. The next simultaneous request grants req0.
- slt signed boundary: op1=0x80000000 op2=0x00000001 cont=111 → result 1, z 0.
